aes_sub_bytes_seq: RTL and testbench

- Iterative forward SubBytes engine for the AES encryption datapath. It is the encrypt-direction counterpart of the existing inverse S-box path.
- Accepts one 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through forward S-box instances.
- Returns the substituted 128-bit state over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the round-iterative encrypt core.

---
 rtl/aes_sub_bytes_seq_pkg.sv | 24 ++
 rtl/aes_sub_bytes_seq_if.sv | 31 +++
 rtl/aes_sub_bytes_seq_sbox.sv | 80 ++++++++
 rtl/aes_sub_bytes_seq.sv | 111 +++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sub_bytes_seq_pkg.sv
// Shared AES definitions for the encrypt-side SubBytes engine: block geometry,
// FSM state encoding and the byte-position helper.
package aes_sub_bytes_seq_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;
    localparam int AES_IDX_W     = $clog2(AES_NUM_BYTES);
    localparam int AES_BIT_W     = $clog2(AES_BLOCK_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sb_state_e;

    // LSB position of byte idx inside a state; byte 0 is the most significant byte.
    function automatic logic [AES_BIT_W-1:0] aes_byte_lsb(input logic [AES_IDX_W-1:0] idx);
        logic [AES_IDX_W-1:0] rev;
        rev = AES_IDX_W'(AES_NUM_BYTES - 1) - idx;
        return {rev, 3'b000};
    endfunction

endpackage

// File: rtl/aes_sub_bytes_seq_if.sv
// Input/output valid-ready handshakes of the SubBytes engine.
// master = producer/consumer side, slave = the engine.
interface aes_sub_bytes_seq_if;
    import aes_sub_bytes_seq_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

endinterface

// File: rtl/aes_sub_bytes_seq_sbox.sv
// Forward AES S-box: purely combinational 8-bit substitution, no registers.
module aes_sub_bytes_seq_sbox
    import aes_sub_bytes_seq_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] data,
    output logic [AES_BYTE_W-1:0] subst
);

    // Full 256-entry lookup of the FIPS-197 forward substitution table.
    always_comb begin
        subst = 8'h00;
        case (data)
            8'h00: subst = 8'h63;  8'h01: subst = 8'h7c;  8'h02: subst = 8'h77;  8'h03: subst = 8'h7b;
            8'h04: subst = 8'hf2;  8'h05: subst = 8'h6b;  8'h06: subst = 8'h6f;  8'h07: subst = 8'hc5;
            8'h08: subst = 8'h30;  8'h09: subst = 8'h01;  8'h0a: subst = 8'h67;  8'h0b: subst = 8'h2b;
            8'h0c: subst = 8'hfe;  8'h0d: subst = 8'hd7;  8'h0e: subst = 8'hab;  8'h0f: subst = 8'h76;
            8'h10: subst = 8'hca;  8'h11: subst = 8'h82;  8'h12: subst = 8'hc9;  8'h13: subst = 8'h7d;
            8'h14: subst = 8'hfa;  8'h15: subst = 8'h59;  8'h16: subst = 8'h47;  8'h17: subst = 8'hf0;
            8'h18: subst = 8'had;  8'h19: subst = 8'hd4;  8'h1a: subst = 8'ha2;  8'h1b: subst = 8'haf;
            8'h1c: subst = 8'h9c;  8'h1d: subst = 8'ha4;  8'h1e: subst = 8'h72;  8'h1f: subst = 8'hc0;
            8'h20: subst = 8'hb7;  8'h21: subst = 8'hfd;  8'h22: subst = 8'h93;  8'h23: subst = 8'h26;
            8'h24: subst = 8'h36;  8'h25: subst = 8'h3f;  8'h26: subst = 8'hf7;  8'h27: subst = 8'hcc;
            8'h28: subst = 8'h34;  8'h29: subst = 8'ha5;  8'h2a: subst = 8'he5;  8'h2b: subst = 8'hf1;
            8'h2c: subst = 8'h71;  8'h2d: subst = 8'hd8;  8'h2e: subst = 8'h31;  8'h2f: subst = 8'h15;
            8'h30: subst = 8'h04;  8'h31: subst = 8'hc7;  8'h32: subst = 8'h23;  8'h33: subst = 8'hc3;
            8'h34: subst = 8'h18;  8'h35: subst = 8'h96;  8'h36: subst = 8'h05;  8'h37: subst = 8'h9a;
            8'h38: subst = 8'h07;  8'h39: subst = 8'h12;  8'h3a: subst = 8'h80;  8'h3b: subst = 8'he2;
            8'h3c: subst = 8'heb;  8'h3d: subst = 8'h27;  8'h3e: subst = 8'hb2;  8'h3f: subst = 8'h75;
            8'h40: subst = 8'h09;  8'h41: subst = 8'h83;  8'h42: subst = 8'h2c;  8'h43: subst = 8'h1a;
            8'h44: subst = 8'h1b;  8'h45: subst = 8'h6e;  8'h46: subst = 8'h5a;  8'h47: subst = 8'ha0;
            8'h48: subst = 8'h52;  8'h49: subst = 8'h3b;  8'h4a: subst = 8'hd6;  8'h4b: subst = 8'hb3;
            8'h4c: subst = 8'h29;  8'h4d: subst = 8'he3;  8'h4e: subst = 8'h2f;  8'h4f: subst = 8'h84;
            8'h50: subst = 8'h53;  8'h51: subst = 8'hd1;  8'h52: subst = 8'h00;  8'h53: subst = 8'hed;
            8'h54: subst = 8'h20;  8'h55: subst = 8'hfc;  8'h56: subst = 8'hb1;  8'h57: subst = 8'h5b;
            8'h58: subst = 8'h6a;  8'h59: subst = 8'hcb;  8'h5a: subst = 8'hbe;  8'h5b: subst = 8'h39;
            8'h5c: subst = 8'h4a;  8'h5d: subst = 8'h4c;  8'h5e: subst = 8'h58;  8'h5f: subst = 8'hcf;
            8'h60: subst = 8'hd0;  8'h61: subst = 8'hef;  8'h62: subst = 8'haa;  8'h63: subst = 8'hfb;
            8'h64: subst = 8'h43;  8'h65: subst = 8'h4d;  8'h66: subst = 8'h33;  8'h67: subst = 8'h85;
            8'h68: subst = 8'h45;  8'h69: subst = 8'hf9;  8'h6a: subst = 8'h02;  8'h6b: subst = 8'h7f;
            8'h6c: subst = 8'h50;  8'h6d: subst = 8'h3c;  8'h6e: subst = 8'h9f;  8'h6f: subst = 8'ha8;
            8'h70: subst = 8'h51;  8'h71: subst = 8'ha3;  8'h72: subst = 8'h40;  8'h73: subst = 8'h8f;
            8'h74: subst = 8'h92;  8'h75: subst = 8'h9d;  8'h76: subst = 8'h38;  8'h77: subst = 8'hf5;
            8'h78: subst = 8'hbc;  8'h79: subst = 8'hb6;  8'h7a: subst = 8'hda;  8'h7b: subst = 8'h21;
            8'h7c: subst = 8'h10;  8'h7d: subst = 8'hff;  8'h7e: subst = 8'hf3;  8'h7f: subst = 8'hd2;
            8'h80: subst = 8'hcd;  8'h81: subst = 8'h0c;  8'h82: subst = 8'h13;  8'h83: subst = 8'hec;
            8'h84: subst = 8'h5f;  8'h85: subst = 8'h97;  8'h86: subst = 8'h44;  8'h87: subst = 8'h17;
            8'h88: subst = 8'hc4;  8'h89: subst = 8'ha7;  8'h8a: subst = 8'h7e;  8'h8b: subst = 8'h3d;
            8'h8c: subst = 8'h64;  8'h8d: subst = 8'h5d;  8'h8e: subst = 8'h19;  8'h8f: subst = 8'h73;
            8'h90: subst = 8'h60;  8'h91: subst = 8'h81;  8'h92: subst = 8'h4f;  8'h93: subst = 8'hdc;
            8'h94: subst = 8'h22;  8'h95: subst = 8'h2a;  8'h96: subst = 8'h90;  8'h97: subst = 8'h88;
            8'h98: subst = 8'h46;  8'h99: subst = 8'hee;  8'h9a: subst = 8'hb8;  8'h9b: subst = 8'h14;
            8'h9c: subst = 8'hde;  8'h9d: subst = 8'h5e;  8'h9e: subst = 8'h0b;  8'h9f: subst = 8'hdb;
            8'ha0: subst = 8'he0;  8'ha1: subst = 8'h32;  8'ha2: subst = 8'h3a;  8'ha3: subst = 8'h0a;
            8'ha4: subst = 8'h49;  8'ha5: subst = 8'h06;  8'ha6: subst = 8'h24;  8'ha7: subst = 8'h5c;
            8'ha8: subst = 8'hc2;  8'ha9: subst = 8'hd3;  8'haa: subst = 8'hac;  8'hab: subst = 8'h62;
            8'hac: subst = 8'h91;  8'had: subst = 8'h95;  8'hae: subst = 8'he4;  8'haf: subst = 8'h79;
            8'hb0: subst = 8'he7;  8'hb1: subst = 8'hc8;  8'hb2: subst = 8'h37;  8'hb3: subst = 8'h6d;
            8'hb4: subst = 8'h8d;  8'hb5: subst = 8'hd5;  8'hb6: subst = 8'h4e;  8'hb7: subst = 8'ha9;
            8'hb8: subst = 8'h6c;  8'hb9: subst = 8'h56;  8'hba: subst = 8'hf4;  8'hbb: subst = 8'hea;
            8'hbc: subst = 8'h65;  8'hbd: subst = 8'h7a;  8'hbe: subst = 8'hae;  8'hbf: subst = 8'h08;
            8'hc0: subst = 8'hba;  8'hc1: subst = 8'h78;  8'hc2: subst = 8'h25;  8'hc3: subst = 8'h2e;
            8'hc4: subst = 8'h1c;  8'hc5: subst = 8'ha6;  8'hc6: subst = 8'hb4;  8'hc7: subst = 8'hc6;
            8'hc8: subst = 8'he8;  8'hc9: subst = 8'hdd;  8'hca: subst = 8'h74;  8'hcb: subst = 8'h1f;
            8'hcc: subst = 8'h4b;  8'hcd: subst = 8'hbd;  8'hce: subst = 8'h8b;  8'hcf: subst = 8'h8a;
            8'hd0: subst = 8'h70;  8'hd1: subst = 8'h3e;  8'hd2: subst = 8'hb5;  8'hd3: subst = 8'h66;
            8'hd4: subst = 8'h48;  8'hd5: subst = 8'h03;  8'hd6: subst = 8'hf6;  8'hd7: subst = 8'h0e;
            8'hd8: subst = 8'h61;  8'hd9: subst = 8'h35;  8'hda: subst = 8'h57;  8'hdb: subst = 8'hb9;
            8'hdc: subst = 8'h86;  8'hdd: subst = 8'hc1;  8'hde: subst = 8'h1d;  8'hdf: subst = 8'h9e;
            8'he0: subst = 8'he1;  8'he1: subst = 8'hf8;  8'he2: subst = 8'h98;  8'he3: subst = 8'h11;
            8'he4: subst = 8'h69;  8'he5: subst = 8'hd9;  8'he6: subst = 8'h8e;  8'he7: subst = 8'h94;
            8'he8: subst = 8'h9b;  8'he9: subst = 8'h1e;  8'hea: subst = 8'h87;  8'heb: subst = 8'he9;
            8'hec: subst = 8'hce;  8'hed: subst = 8'h55;  8'hee: subst = 8'h28;  8'hef: subst = 8'hdf;
            8'hf0: subst = 8'h8c;  8'hf1: subst = 8'ha1;  8'hf2: subst = 8'h89;  8'hf3: subst = 8'h0d;
            8'hf4: subst = 8'hbf;  8'hf5: subst = 8'he6;  8'hf6: subst = 8'h42;  8'hf7: subst = 8'h68;
            8'hf8: subst = 8'h41;  8'hf9: subst = 8'h99;  8'hfa: subst = 8'h2d;  8'hfb: subst = 8'h0f;
            8'hfc: subst = 8'hb0;  8'hfd: subst = 8'h54;  8'hfe: subst = 8'hbb;  8'hff: subst = 8'h16;
        endcase
    end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Iterative forward SubBytes engine: takes one 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per clock, then presents the result until accepted.
module aes_sub_bytes_seq
    import aes_sub_bytes_seq_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes_sub_bytes_seq_if.slave bus
);

    localparam int NUM_CHUNKS = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
        $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    sb_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] work_q, work_d;
    logic                   out_vld_q, out_vld_d;
    logic [AES_BLOCK_W-1:0] out_state_q, out_state_d;

    logic [AES_IDX_W-1:0]   chunk_base;
    logic [AES_BYTE_W-1:0]  sb_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]  sb_out [BYTES_PER_CYCLE];

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        aes_sub_bytes_seq_sbox u_sbox (
            .data  (sb_in[g]),
            .subst (sb_out[g])
        );
    end

    // Route the bytes of the current chunk of the working register into the S-box lanes.
    always_comb begin
        chunk_base = AES_IDX_W'(int'(cnt_q) * BYTES_PER_CYCLE);
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sb_in[j] = work_q[aes_byte_lsb(chunk_base + AES_IDX_W'(j)) +: AES_BYTE_W];
        end
    end

    // Next-state logic: capture in IDLE, substitute one chunk per BUSY cycle,
    // publish the result in DONE and hold it until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_vld_d   = out_vld_q;
        out_state_d = out_state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_state;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    work_d[aes_byte_lsb(chunk_base + AES_IDX_W'(j)) +: AES_BYTE_W] = sb_out[j];
                end
                // Wrap on the last chunk so the counter never points outside the state.
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!out_vld_q) begin
                    out_vld_d   = 1'b1;
                    out_state_d = work_q;
                end else if (bus.out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_vld_q   <= 1'b0;
            out_state_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_vld_q   <= out_vld_d;
            out_state_q <= out_state_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_vld_q;
    assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: one instance per legal BYTES_PER_CYCLE, a
// GF(2^8)-derived S-box reference, directed vectors and handshake corner cases.
module tb_aes_sub_bytes_seq;

    localparam int NINST = 5;   // instance k uses BYTES_PER_CYCLE = 1 << k

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NINST-1:0] rst_v;
    logic [NINST-1:0] in_valid_v;
    logic [NINST-1:0] in_ready_v;
    logic [NINST-1:0] out_valid_v;
    logic [NINST-1:0] out_ready_v;
    logic [127:0]     in_state_a  [NINST];
    logic [127:0]     out_state_a [NINST];

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        aes_sub_bytes_seq_if bus ();
        assign bus.in_valid    = in_valid_v[gi];
        assign bus.in_state    = in_state_a[gi];
        assign bus.out_ready   = out_ready_v[gi];
        assign in_ready_v[gi]  = bus.in_ready;
        assign out_valid_v[gi] = bus.out_valid;
        assign out_state_a[gi] = bus.out_state;
        aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << gi)) u_dut (
            .clk (clk),
            .rst (rst_v[gi]),
            .bus (bus)
        );
    end

    int checks;
    int errors;
    logic [7:0] sbox_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq = x; inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_ref[st[i*8 +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present st and return just after the accepting edge.
    task automatic send(input int k, input logic [127:0] st, input string name);
        int t;
        t = 0;
        in_state_a[k] = st;
        in_valid_v[k] = 1'b1;
        while (!in_ready_v[k] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_accept"}, {127'd0, in_ready_v[k]}, 128'd1);
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!out_valid_v[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int k, input logic [127:0] st, input logic [127:0] exp,
                           input string name);
        int lat;
        send(k, st, name);
        wait_out(k, lat);
        chk({name, "_latency"}, 128'(lat), 128'((16 >> k) + 1));
        chk({name, "_state"}, out_state_a[k], exp);
        out_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[k] = 1'b0;
        chk({name, "_valid_drop"}, {127'd0, out_valid_v[k]}, 128'd0);
        chk({name, "_ready_back"}, {127'd0, in_ready_v[k]}, 128'd1);
    endtask

    typedef struct {
        int           k;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] st, st_b, exp_st;
    logic [127:0] got [2];
    int           lat, acc, got_n, overlap, pulses;
    logic         acc_now;

    initial begin
        checks = 0;
        errors = 0;
        for (int v = 0; v < 256; v++) sbox_ref[v] = sbox_calc(8'(v));

        vecs[0] = '{k: 0, st: 128'h000153ff_00000000_00000000_00000000,
                          exp: 128'h637ced16_63636363_63636363_63636363};
        vecs[1] = '{k: 2, st: 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808,
                          exp: 128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
        vecs[2] = '{k: 4, st: 128'h0, exp: {16{8'h63}}};
        vecs[3] = '{k: 3, st: {16{8'hff}}, exp: {16{8'h16}}};

        rst_v       = '1;
        in_valid_v  = '0;
        out_ready_v = '0;
        for (int k = 0; k < NINST; k++) in_state_a[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_v = '0;

        for (int k = 0; k < NINST; k++) begin
            chk($sformatf("reset_in_ready_%0d", k), {127'd0, in_ready_v[k]}, 128'd1);
            chk($sformatf("reset_out_valid_%0d", k), {127'd0, out_valid_v[k]}, 128'd0);
            chk($sformatf("reset_out_state_%0d", k), out_state_a[k], 128'd0);
        end

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i].k, vecs[i].st, vecs[i].exp, $sformatf("vec%0d", i));

        // Backpressure: result and handshake state must hold through a 10-cycle stall.
        st     = 128'h00112233_44556677_8899aabb_ccddeeff;
        exp_st = sub_ref(st);
        send(2, st, "bp");
        wait_out(2, lat);
        chk("bp_latency", 128'(lat), 128'd5);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", {127'd0, out_valid_v[2]}, 128'd1);
            chk("bp_state", out_state_a[2], exp_st);
            chk("bp_in_ready", {127'd0, in_ready_v[2]}, 128'd0);
            @(posedge clk); #1;
        end
        out_ready_v[2] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[2] = 1'b0;
        chk("bp_release_valid", {127'd0, out_valid_v[2]}, 128'd0);
        chk("bp_release_ready", {127'd0, in_ready_v[2]}, 128'd1);

        // Back-to-back: in_valid stays high across two states; no overlap, no loss.
        st   = {$urandom, $urandom, $urandom, $urandom};
        st_b = {$urandom, $urandom, $urandom, $urandom};
        acc = 0; got_n = 0; overlap = 0;
        got[0] = '0; got[1] = '0;
        in_state_a[1]  = st;
        in_valid_v[1]  = 1'b1;
        out_ready_v[1] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            acc_now = in_valid_v[1] & in_ready_v[1];
            if (in_ready_v[1] && acc > got_n) overlap++;
            if (out_valid_v[1] && out_ready_v[1]) begin
                if (got_n < 2) got[got_n] = out_state_a[1];
                got_n++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                acc++;
                if (acc == 1) in_state_a[1] = st_b;
                else          in_valid_v[1] = 1'b0;
            end
        end
        in_valid_v[1]  = 1'b0;
        out_ready_v[1] = 1'b0;
        chk("b2b_accepts", 128'(acc), 128'd2);
        chk("b2b_outputs", 128'(got_n), 128'd2);
        chk("b2b_overlap", 128'(overlap), 128'd0);
        chk("b2b_result_a", got[0], sub_ref(st));
        chk("b2b_result_b", got[1], sub_ref(st_b));

        // Reset on the second BUSY cycle discards the operation.
        send(2, 128'hdeadbeef_01234567_89abcdef_fedcba98, "rst_mid");
        @(posedge clk); #1;
        rst_v[2] = 1'b1;
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        chk("rst_mid_in_ready", {127'd0, in_ready_v[2]}, 128'd1);
        chk("rst_mid_out_valid", {127'd0, out_valid_v[2]}, 128'd0);
        chk("rst_mid_out_state", out_state_a[2], 128'd0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid_v[2]) pulses++;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_pulse", 128'(pulses), 128'd0);
        st = 128'h3243f6a8_885a308d_313198a2_e0370734;
        run_vec(2, st, sub_ref(st), "post_rst");

        // Random sweep over every legal BYTES_PER_CYCLE.
        for (int k = 0; k < NINST; k++) begin
            for (int n = 0; n < 200; n++) begin
                st = {$urandom, $urandom, $urandom, $urandom};
                run_vec(k, st, sub_ref(st), $sformatf("rand_B%0d_%0d", 1 << k, n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
